// File: rtl/level_hold_counter_multi_pkg.sv
// Shared types and tick-rate constants for the level hold counters.
package level_counter_pkg;

  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

  localparam int unsigned TICK_DIV_2HZ = 50_000_000;
  localparam int unsigned TICK_DIV_1HZ = 100_000_000;

endpackage

// File: rtl/level_hold_counter_multi_if.sv
// Channel-side signal bundle of the multi-channel level hold counter.
interface level_hold_counter_multi_if #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned COUNT_BITS = 8
) ();

  logic [N_CH-1:0]            lv_in;
  logic [N_CH-1:0]            clear;
  logic [N_CH*COUNT_BITS-1:0] hold_count;
  logic [N_CH-1:0]            overflow;
  logic [N_CH-1:0]            active;
  logic                       tick;

  modport master (
    output lv_in,
    output clear,
    input  hold_count,
    input  overflow,
    input  active,
    input  tick
  );

  modport slave (
    input  lv_in,
    input  clear,
    output hold_count,
    output overflow,
    output active,
    output tick
  );

endinterface

// File: rtl/level_hold_counter_multi_tick_gen.sv
// Clock-enable generator: one-cycle tick every TICK_DIV cycles of CLK100MHZ.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic CLK100MHZ,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntBits = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntBits-1:0] LastCnt = CntBits'(TICK_DIV - 1);

  logic [CntBits-1:0] r_cnt;
  logic               w_at_last;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_at_last = (r_cnt == LastCnt);
  // Masked during reset so TICK_DIV=1 still reads 0 while reset is held.
  assign tick = w_at_last & ~reset;

endmodule

// File: rtl/level_hold_counter_multi.sv
// Multi-channel level hold counter: counts ticks during which each synchronised level is high.
module level_hold_counter_multi
  import level_counter_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned COUNT_BITS = 8,
  parameter int unsigned TICK_DIV   = TICK_DIV_2HZ,
  parameter cnt_mode_e   MODE       = CNT_SAT
) (
  input logic                      CLK100MHZ,
  input logic                      reset,
  level_hold_counter_multi_if.slave bus
);

  localparam logic [COUNT_BITS-1:0] CountMax = '1;

  logic                       w_tick;
  logic [N_CH-1:0]            r_sync1;
  logic [N_CH-1:0]            r_sync2;
  logic [N_CH*COUNT_BITS-1:0] w_hold_count;
  logic [N_CH-1:0]            w_overflow;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .tick      (w_tick)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.lv_in;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [COUNT_BITS-1:0] r_count;
    logic                  r_ovf;

    // Clear outranks a coincident tick; the increment in that cycle is dropped.
    always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (bus.clear[g]) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_tick && r_sync2[g]) begin
        if (r_count == CountMax) begin
          r_ovf <= 1'b1;
          if (MODE == CNT_WRAP) begin
            r_count <= '0;
          end
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
    end

    assign w_hold_count[g*COUNT_BITS +: COUNT_BITS] = r_count;
    assign w_overflow[g]                            = r_ovf;
  end

  assign bus.hold_count = w_hold_count;
  assign bus.overflow   = w_overflow;
  assign bus.active     = r_sync2;
  assign bus.tick       = w_tick;

endmodule

// File: tb/tb_level_hold_counter_multi.sv
// Bench: a saturating and a wrapping instance run side by side against a reference model.
module tb_level_hold_counter_multi;
  import level_counter_pkg::*;

  localparam int TDIV = 4;
  localparam int MAXV = 7;

  typedef struct {
    logic [1:0] lv_sat;
    logic [1:0] lv_wrap;
    int         ticks;
    logic [5:0] sat_cnt;
    logic [1:0] sat_ovf;
    logic [5:0] wrap_cnt;
    logic [1:0] wrap_ovf;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] lv_d  [2];
  logic [1:0] clr_d [2];
  logic [5:0] act_cnt [2];
  logic [1:0] act_ovf [2];
  logic [1:0] act_act [2];
  logic       act_tick[2];

  int checks = 0;
  int errors = 0;
  string dn[2] = '{"sat", "wrap"};

  level_hold_counter_multi_if #(.N_CH(2), .COUNT_BITS(3)) if_sat  ();
  level_hold_counter_multi_if #(.N_CH(2), .COUNT_BITS(3)) if_wrap ();

  level_hold_counter_multi #(
    .N_CH(2), .COUNT_BITS(3), .TICK_DIV(TDIV), .MODE(CNT_SAT)
  ) u_sat (
    .CLK100MHZ (clk),
    .reset     (rst),
    .bus       (if_sat)
  );

  level_hold_counter_multi #(
    .N_CH(2), .COUNT_BITS(3), .TICK_DIV(TDIV), .MODE(CNT_WRAP)
  ) u_wrap (
    .CLK100MHZ (clk),
    .reset     (rst),
    .bus       (if_wrap)
  );

  assign if_sat.lv_in  = lv_d[0];
  assign if_sat.clear  = clr_d[0];
  assign if_wrap.lv_in = lv_d[1];
  assign if_wrap.clear = clr_d[1];
  assign act_cnt[0]  = if_sat.hold_count;
  assign act_cnt[1]  = if_wrap.hold_count;
  assign act_ovf[0]  = if_sat.overflow;
  assign act_ovf[1]  = if_wrap.overflow;
  assign act_act[0]  = if_sat.active;
  assign act_act[1]  = if_wrap.active;
  assign act_tick[0] = if_sat.tick;
  assign act_tick[1] = if_wrap.tick;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tick phase counted since reset, counts as plain integers,
  // and each level seen by the counter two edges after it was sampled.
  int         phase = 0;
  int         m_cnt [2][2];
  bit         m_ovf [2][2];
  logic [1:0] m_seen_last [2];
  logic [1:0] m_seen_prev [2];
  bit         m_tick;
  logic [5:0] e_cnt;

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_seen_last[d] = '0;
      m_seen_prev[d] = '0;
      for (int c = 0; c < 2; c++) begin
        m_cnt[d][c] = 0;
        m_ovf[d][c] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    m_tick = !rst && ((phase % TDIV) == TDIV - 1);
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (rst || clr_d[d][c]) begin
          m_cnt[d][c] = 0;
          m_ovf[d][c] = 1'b0;
        end else if (m_tick && m_seen_prev[d][c]) begin
          if (m_cnt[d][c] == MAXV) begin
            m_ovf[d][c] = 1'b1;
            m_cnt[d][c] = (d == 0) ? MAXV : 0;
          end else begin
            m_cnt[d][c] = m_cnt[d][c] + 1;
          end
        end
      end
      m_seen_prev[d] = rst ? 2'b00 : m_seen_last[d];
      m_seen_last[d] = rst ? 2'b00 : lv_d[d];
    end
    phase = rst ? 0 : phase + 1;
    #3;
    for (int d = 0; d < 2; d++) begin
      e_cnt = {3'(m_cnt[d][1]), 3'(m_cnt[d][0])};
      chk({dn[d], " model cnt"}, 32'(act_cnt[d]), 32'(e_cnt));
      chk({dn[d], " model ovf"}, 32'(act_ovf[d]), 32'({m_ovf[d][1], m_ovf[d][0]}));
      chk({dn[d], " model active"}, 32'(act_act[d]), 32'(m_seen_prev[d]));
      chk({dn[d], " model tick"}, 32'(act_tick[d]), 32'(!rst && ((phase % TDIV) == TDIV - 1)));
    end
  end

  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (!act_tick[0] && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("tick timeout", 32'(act_tick[0]), 32'd1);
  endtask

  task automatic wait_tick_edge();
    wait_tick();
    @(negedge clk);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'b01, 2'b11, 1, 6'o01, 2'b00, 6'o11, 2'b00};
    vecs[1] = '{2'b01, 2'b11, 1, 6'o02, 2'b00, 6'o22, 2'b00};
    vecs[2] = '{2'b01, 2'b11, 1, 6'o03, 2'b00, 6'o33, 2'b00};
    vecs[3] = '{2'b01, 2'b11, 1, 6'o04, 2'b00, 6'o44, 2'b00};
    vecs[4] = '{2'b01, 2'b11, 1, 6'o05, 2'b00, 6'o55, 2'b00};
    vecs[5] = '{2'b01, 2'b11, 1, 6'o06, 2'b00, 6'o66, 2'b00};
    vecs[6] = '{2'b01, 2'b11, 1, 6'o07, 2'b00, 6'o77, 2'b00};
    vecs[7] = '{2'b01, 2'b11, 1, 6'o07, 2'b01, 6'o00, 2'b11};
    vecs[8] = '{2'b01, 2'b11, 1, 6'o07, 2'b01, 6'o11, 2'b11};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      lv_d[d]  = 2'b00;
      clr_d[d] = 2'b00;
    end

    // Reset release and tick cadence.
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk({dn[d], " rst cnt"}, 32'(act_cnt[d]), 32'd0);
      chk({dn[d], " rst ovf"}, 32'(act_ovf[d]), 32'd0);
      chk({dn[d], " rst active"}, 32'(act_act[d]), 32'd0);
    end
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) #1;
      chk($sformatf("tick cycle %0d", c), 32'(act_tick[0]), 32'((c % TDIV) == 0));
      @(negedge clk);
    end

    // Saturate and wrap counting from the table.
    for (int i = 0; i < 9; i++) begin
      lv_d[0] = vecs[i].lv_sat;
      lv_d[1] = vecs[i].lv_wrap;
      repeat (vecs[i].ticks) wait_tick_edge();
      chk($sformatf("vec %0d sat cnt", i), 32'(act_cnt[0]), 32'(vecs[i].sat_cnt));
      chk($sformatf("vec %0d sat ovf", i), 32'(act_ovf[0]), 32'(vecs[i].sat_ovf));
      chk($sformatf("vec %0d wrap cnt", i), 32'(act_cnt[1]), 32'(vecs[i].wrap_cnt));
      chk($sformatf("vec %0d wrap ovf", i), 32'(act_ovf[1]), 32'(vecs[i].wrap_ovf));
    end

    // Clear coincident with tick on wrap ch0; ch1 keeps counting.
    repeat (4) wait_tick_edge();
    chk("pre-clear wrap cnt", 32'(act_cnt[1]), 32'(6'o55));
    chk("pre-clear wrap ovf", 32'(act_ovf[1]), 32'd3);
    wait_tick();
    clr_d[1] = 2'b01;
    @(negedge clk);
    clr_d[1] = 2'b00;
    chk("clear wrap cnt", 32'(act_cnt[1]), 32'(6'o60));
    chk("clear wrap ovf", 32'(act_ovf[1]), 32'd2);

    // Synchroniser timing on sat ch0.
    lv_d[0] = 2'b00;
    repeat (3) @(negedge clk);
    clr_d[0] = 2'b11;
    @(negedge clk);
    clr_d[0] = 2'b00;
    chk("sync cleared cnt", 32'(act_cnt[0]), 32'd0);
    wait_tick_edge();
    @(negedge clk);
    lv_d[0] = 2'b01;
    wait_tick_edge();
    chk("sync 2-edge counted", 32'(act_cnt[0]), 32'd1);
    lv_d[0] = 2'b00;
    wait_tick_edge();
    chk("sync low hold", 32'(act_cnt[0]), 32'd1);
    repeat (2) @(negedge clk);
    lv_d[0] = 2'b01;
    wait_tick_edge();
    chk("sync 1-edge missed", 32'(act_cnt[0]), 32'd1);
    wait_tick_edge();
    chk("sync next tick counted", 32'(act_cnt[0]), 32'd2);
    lv_d[0] = 2'b00;
    wait_tick_edge();
    lv_d[0] = 2'b01;
    @(negedge clk);
    lv_d[0] = 2'b00;
    wait_tick_edge();
    chk("sync pulse ignored", 32'(act_cnt[0]), 32'd2);

    // One-cycle reset just before a tick restarts the phase.
    lv_d[0] = 2'b11;
    wait_tick_edge();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("post-reset tick %0d", c), 32'(act_tick[0]), 32'(c == 4));
      if (c == 1) begin
        chk("post-reset sat cnt", 32'(act_cnt[0]), 32'd0);
        chk("post-reset wrap cnt", 32'(act_cnt[1]), 32'd0);
        chk("post-reset ovf", 32'({act_ovf[1], act_ovf[0]}), 32'd0);
      end
      @(negedge clk);
    end

    // Random levels, clears and occasional resets against the model.
    for (int k = 0; k < 400; k++) begin
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 3) == 0) lv_d[d] = 2'($urandom);
        clr_d[d] = ($urandom_range(0, 39) == 0) ? 2'($urandom) : 2'b00;
      end
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
